braille_key_capture: RTL
========================

Name: braille_key_capture

Overview:
- Input front end of the Braille trainer datapath.
- Takes the raw, asynchronous "enter" push-button and the four raw dot-entry switches from the board.
- Synchronises and debounces the button, then latches the synchronised switch pattern once per clean press.
- Presents the latched pattern as a 4-bit code with a one-cycle valid strobe, which drives the In/Valid inputs of the downstream load/register stage.

Parameters:
- DEBOUNCE_CYCLES, 50000, cycles the synchronised button must stay stable to accept a press or release (1 ms at 50 MHz); legal range 2 .. 2^CNT_W-1.
- CNT_W, 16, debounce counter width.

Ports:
- Clk  input  1  system clock; all flops on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Btn  input  1  raw enter button, active-high, asynchronous, bouncy.
- Sw  input  4  raw dot switches, asynchronous; bit i = dot i+1.
- Code  output  4  registered captured dot pattern.
- Valid  output  1  registered one-cycle strobe; Code is new in the same cycle.
- Busy  output  1  high whenever the FSM is not IDLE.

Interface (already decided): one clock, Clk; reset Rst is asynchronous and active-high.

Behaviour:
- Reset (async, any time, including mid-debounce):
  - Code=0, Valid=0, Busy=0, state=IDLE, counter=0.
  - Synchroniser flops cleared to 0.
  - Valid drops immediately on Rst assertion, not at the next edge.
- Synchronisation:
  - Btn and Sw each pass through 2 flops, giving btn_s and sw_s.
  - All FSM decisions use btn_s and sw_s only.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: btn_s=1 -> PRESS_WAIT, counter<=0. Otherwise stay.
  - PRESS_WAIT:
    - btn_s=0 -> IDLE (bounce rejected, no Valid).
    - btn_s=1 and counter<DEBOUNCE_CYCLES-1 -> counter++.
    - btn_s=1 and counter==DEBOUNCE_CYCLES-1 -> HELD; same edge Code<=sw_s and Valid<=1.
  - HELD: btn_s=0 -> RELEASE_WAIT, counter<=0. Otherwise stay; no further Valid while held.
  - RELEASE_WAIT:
    - btn_s=1 -> HELD (release bounce; no new Valid).
    - btn_s=0 and counter<DEBOUNCE_CYCLES-1 -> counter++.
    - btn_s=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE.
- Valid: high for exactly one cycle per accepted press; 0 on every other cycle.
- Code: holds its value between accepts; changes only on the accept edge; unaffected by Sw motion at any other time.
- Latency: with raw Btn stable high from cycle 0, Valid is high in cycle DEBOUNCE_CYCLES+3 (2 sync + 1 IDLE + DEBOUNCE_CYCLES count).
- Switch sampling: Sw changing after the accept edge does not alter Code. Sw changes within the 2-cycle synchroniser window before accept are captured as whatever sw_s holds at the accept edge; Code is never a mixture of partially changed bits beyond that.
- Counter: never exceeds DEBOUNCE_CYCLES-1, so no wrap.
- Busy = (state != IDLE), registered-state decode.
- After reset release with Btn already high, a full fresh debounce is required before Valid.

Decomposition:
- Shared package braille_pkg:
  - CODE_W=4.
  - FSM state enum key_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Default DEBOUNCE_CYCLES constant.
- Sub-module sync_2ff:
  - Parameter WIDTH; async active-high clear.
  - Instantiated once for Btn (WIDTH=1) and once for Sw (WIDTH=4).
- FSM, counter, and the Code/Valid registers stay in braille_key_capture.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset: assert Rst between clock edges -> Code=0000, Valid=0, Busy=0 before the next edge; holds while Rst=1.
2. Clean press: Sw=1010 stable, Btn high 20 cycles from cycle 0 -> single Valid in cycle 7 with Code=1010; Busy high from cycle 3; no second Valid.
3. Press bounce: Btn 1,1,0,1,1,0 then low -> Valid never asserts; FSM returns to IDLE; Code unchanged.
4. Release bounce: after case 2, Btn low 2 cycles, high 1, then low 10 -> no extra Valid; Busy falls after the final debounce. Then Sw=0101 and a clean press -> Valid once, Code=0101.
5. Reset mid-debounce: Btn high; assert Rst in PRESS_WAIT with counter=2; release Rst with Btn still high -> no Valid before release; Valid exactly 7 cycles after Rst deassertion.
6. Switch change while HELD: accept with Sw=0011, then Sw=1111 while held -> Code stays 0011 and Valid stays 0 until the next full press.

Source files
------------

// File: rtl/braille_pkg.sv
// -----------------------------------------------------------------------------
// braille_pkg
// Shared definitions for the Braille trainer input front end.
//   CODE_W                  - width of the dot pattern (one bit per dot)
//   DEBOUNCE_CYCLES_DEFAULT - stable cycles required to accept a press/release
//                             (1 ms at 50 MHz)
//   CNT_W_DEFAULT           - debounce counter width
//   key_state_t             - key capture FSM states
// -----------------------------------------------------------------------------
package braille_pkg;

    localparam int CODE_W                  = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int CNT_W_DEFAULT           = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

endpackage

// File: rtl/braille_key_capture_if.sv
// -----------------------------------------------------------------------------
// braille_key_capture_if
// Board-side and downstream signals of the key capture block.
//   Btn   - raw enter button, active-high, asynchronous, bouncy
//   Sw    - raw dot switches, bit i = dot i+1
//   Code  - captured dot pattern
//   Valid - one-cycle strobe, Code is new in the same cycle
//   Busy  - capture FSM is not idle
// master: the side driving the raw inputs (board / bench)
// slave : the key capture block itself
// -----------------------------------------------------------------------------
interface braille_key_capture_if;

    logic                           Btn;
    logic [braille_pkg::CODE_W-1:0] Sw;
    logic [braille_pkg::CODE_W-1:0] Code;
    logic                           Valid;
    logic                           Busy;

    modport master (
        output Btn,
        output Sw,
        input  Code,
        input  Valid,
        input  Busy
    );

    modport slave (
        input  Btn,
        input  Sw,
        output Code,
        output Valid,
        output Busy
    );

endinterface

// File: rtl/braille_key_capture_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous inputs. Each bit is synchronised
// independently; the bus is not coherent across bits.
//   i_clk - destination clock
//   i_rst - asynchronous, active-high clear (both stages to 0)
//   i_d   - asynchronous input
//   o_q   - synchronised output, two cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge; blocking here would collapse
    // the two flops into one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/braille_key_capture.sv
// -----------------------------------------------------------------------------
// braille_key_capture
// Synchronises and debounces the enter button, then latches the synchronised
// dot switches once per clean press and presents them with a one-cycle strobe.
//   Clk            - system clock, rising edge
//   Rst            - asynchronous, active-high reset
//   bus.Btn/bus.Sw - raw button and dot switches
//   bus.Code       - registered captured pattern, changes only on accept
//   bus.Valid      - registered one-cycle strobe per accepted press
//   bus.Busy       - high whenever the FSM is not IDLE
// Parameters:
//   DEBOUNCE_CYCLES - stable cycles to accept a press or release (2..2^CNT_W-1)
//   CNT_W           - debounce counter width
// -----------------------------------------------------------------------------
module braille_key_capture
    import braille_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Rst,
    braille_key_capture_if.slave  bus
);

    // Terminal count: the counter stops here, so it can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              w_btn_s;
    logic [CODE_W-1:0] w_sw_s;

    key_state_t        r_state;
    key_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_cnt_done;
    logic              w_accept;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;

    // -------------------------------------------------------------------------
    // Synchronisers: every FSM decision below uses only the synchronised copies.
    // -------------------------------------------------------------------------
    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_d   (bus.Btn),
        .o_q   (w_btn_s)
    );

    sync_2ff #(.WIDTH(CODE_W)) u_sync_sw (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_d   (bus.Sw),
        .o_q   (w_sw_s)
    );

    assign w_cnt_done = (r_cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // Next-state / counter / accept decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so no path
    // leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    // Bounce during the press window: drop it silently.
                    w_state_next = IDLE;
                end else if (w_cnt_done) begin
                    w_state_next = HELD;
                    w_accept     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            HELD: begin
                if (!w_btn_s) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end

            RELEASE_WAIT: begin
                if (w_btn_s) begin
                    // Release bounce: back to HELD without a new strobe.
                    w_state_next = HELD;
                end else if (w_cnt_done) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_accept;
            // Code only moves on the accept edge; switch motion at any other
            // time is ignored.
            if (w_accept) begin
                r_code <= w_sw_s;
            end
        end
    end

    assign bus.Code  = r_code;
    assign bus.Valid = r_valid;
    assign bus.Busy  = (r_state != IDLE);

endmodule
